// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e : request FSM states (IDLE / WAIT / DROP)
//   NOP_INSTR     : canonical bubble instruction (addi x0,x0,0)
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register plus a one-entry hold buffer.
//   clk, rst            : clock, synchronous active-high reset
//   StallD, FlushD      : decode stall / redirect kill
//   deliver             : a fetch response is accepted this cycle
//   rdata, req_pc       : instruction word and its PC for the delivery
//   InstrD/PCD/PCPlus4D : IF/ID fields
//   ValidD              : IF/ID holds a real instruction
//   hold_v              : hold buffer occupied (blocks new fetches upstream)
module if_id_register #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(fetch_pkg::NOP_INSTR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             deliver,
    input  logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] req_pc,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCD,
    output logic [WIDTH-1:0] PCPlus4D,
    output logic             ValidD,
    output logic             hold_v
);

    logic [WIDTH-1:0] hold_instr;
    logic [WIDTH-1:0] hold_pc;
    logic             free;

    // A stalled bubble may still be overwritten: only a valid, stalled entry blocks a load.
    assign free = !ValidD || !StallD;

    always_ff @(posedge clk) begin
        if (rst) begin
            ValidD     <= 1'b0;
            InstrD     <= NOP_INSTR;
            PCD        <= '0;
            PCPlus4D   <= '0;
            hold_v     <= 1'b0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else if (FlushD) begin
            ValidD <= 1'b0;
            InstrD <= NOP_INSTR;
            hold_v <= 1'b0;
        end else if (hold_v && !StallD) begin
            ValidD   <= 1'b1;
            InstrD   <= hold_instr;
            PCD      <= hold_pc;
            PCPlus4D <= hold_pc + WIDTH'(4);
            hold_v   <= 1'b0;
        end else if (deliver && free) begin
            ValidD   <= 1'b1;
            InstrD   <= rdata;
            PCD      <= req_pc;
            PCPlus4D <= req_pc + WIDTH'(4);
        end else if (deliver) begin
            // IF/ID is occupied and stalled: park the response until decode moves.
            hold_v     <= 1'b1;
            hold_instr <= rdata;
            hold_pc    <= req_pc;
        end else if (!StallD) begin
            ValidD <= 1'b0;
            InstrD <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding imem request at a time, variable
// response latency, wrong-path responses discarded after a redirect.
//   clk, rst                  : clock, synchronous active-high reset
//   PCF                       : fetch PC from program_counter
//   StallD, FlushD            : decode stall / redirect from the hazard unit
//   imem_req, imem_addr       : single-cycle request pulse and its address
//   imem_rvalid, imem_rdata   : response strobe and instruction word
//   StallF                    : holds the PC while no request can be issued
//   InstrD/PCD/PCPlus4D/ValidD: IF/ID pipeline register outputs
module fetch_stage #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(fetch_pkg::NOP_INSTR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PCF,
    input  logic             StallD,
    input  logic             FlushD,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             StallF,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCD,
    output logic [WIDTH-1:0] PCPlus4D,
    output logic             ValidD
);

    import fetch_pkg::*;

    fetch_state_e     state;
    fetch_state_e     state_nxt;
    logic [WIDTH-1:0] req_pc;
    logic             hold_v;
    logic             issue;
    logic             deliver;

    assign issue     = !rst && (state == IDLE) && !FlushD && !hold_v;
    assign imem_req  = issue;
    assign imem_addr = PCF;
    // Released on a redirect so the PC can load the new target.
    assign StallF    = !rst && !issue && !FlushD;
    assign deliver   = (state == WAIT) && imem_rvalid && !FlushD;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (issue) state_nxt = WAIT;
            WAIT: begin
                if (imem_rvalid)  state_nxt = IDLE;
                else if (FlushD)  state_nxt = DROP;
            end
            DROP: if (imem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            req_pc <= '0;
        end else begin
            state <= state_nxt;
            if (issue) req_pc <= PCF;
        end
    end

    if_id_register #(
        .WIDTH     (WIDTH),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .StallD   (StallD),
        .FlushD   (FlushD),
        .deliver  (deliver),
        .rdata    (imem_rdata),
        .req_pc   (req_pc),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD),
        .hold_v   (hold_v)
    );

endmodule
